dds_sweep_controller: RTL and testbench

Sequences the DDS phase generator through a programmed frequency sweep for lock-in frequency-response measurements. It drives the DDS phase increment, enable and (optionally) reset. It times a settle interval and a dwell measured in DDS output periods, then hands each step to the downstream averager with a valid/ack handshake. It sits between the HPS-side register bank and the DDS/lock-in datapath.

---
 rtl/dds_sweep_pkg.sv | 21 ++
 rtl/dds_sweep_controller_dwell_counter.sv | 41 ++++
 rtl/dds_sweep_controller.sv | 182 ++++++++++++++++++
 tb/tb_dds_sweep_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_sweep_pkg.sv
// dds_sweep_pkg
// Shared definitions for the DDS frequency-sweep controller.
//   - Default widths: B_acumulador (phase increment), B_steps (step count/index),
//     B_cnt (settle and dwell counters).
//   - Sweep FSM state encoding, kept as plain localparam constants so older
//     tooling in this codebase can consume them.
package dds_sweep_pkg;

  localparam int unsigned B_acumulador = 27;
  localparam int unsigned B_steps      = 16;
  localparam int unsigned B_cnt        = 32;

  typedef logic [2:0] sweep_state_t;

  localparam sweep_state_t StIdle    = 3'd0;
  localparam sweep_state_t StSettle  = 3'd1;
  localparam sweep_state_t StDwell   = 3'd2;
  localparam sweep_state_t StWaitAck = 3'd3;
  localparam sweep_state_t StDone    = 3'd4;

endpackage

// File: rtl/dds_sweep_controller_dwell_counter.sv
// sweep_dwell_counter
// Counts DDS output periods (zero_cross pulses) during the dwell of one step.
// Ports:
//   clk       in   system clock
//   reset_n   in   synchronous active-low reset
//   i_clear   in   hold count at zero (asserted whenever the FSM is not dwelling)
//   i_enable  in   count one period this cycle
//   i_target  in   number of periods to dwell (must be >= 1)
//   o_tc      out  the period counted this cycle is the last one of the dwell
module sweep_dwell_counter
  import dds_sweep_pkg::*;
#(
  parameter int unsigned Width = B_cnt
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [Width-1:0] i_target,
  output logic             o_tc
);

  logic [Width-1:0] r_count;
  logic [Width-1:0] w_count_inc;

  assign w_count_inc = r_count + Width'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_count_inc;
    end
  end

  // Terminal count fires on the edge where the count reaches the target.
  assign o_tc = i_enable && (w_count_inc == i_target);

endmodule

// File: rtl/dds_sweep_controller.sv
// dds_sweep_controller
// Steps the DDS phase increment through a programmed sweep. Each step: settle for
// settle_cycles+1 clocks, dwell for dwell_periods DDS periods (acq_enable high),
// then present step_valid/step_index until step_ack.
// Optional feature macro: SWEEP_PHASE_RESET_EN -- when defined, dds_reset_n pulses
// low for one cycle on every entry into SETTLE so each step starts at phase 0;
// otherwise dds_reset_n is tied high and phase is continuous.
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   start, abort              sweep control (abort has priority)
//   inc_start, inc_step       first increment and per-step addend
//   n_steps                   step count (0 means 1)
//   settle_cycles             settle length in clocks
//   dwell_periods             dwell length in zero_cross pulses (0 means 1)
//   zero_cross                period marker from the DDS
//   step_ack                  downstream consumed the current step
//   incremento_fase           phase increment to the DDS
//   dds_enable, dds_reset_n   DDS controls
//   acq_enable                averager gate (DWELL)
//   step_valid, step_index    step handshake to the averager
//   busy, done, ovf           status (ovf sticky, cleared on start)
module dds_sweep_controller
  import dds_sweep_pkg::*;
#(
  parameter int unsigned B_acumulador = dds_sweep_pkg::B_acumulador,
  parameter int unsigned B_steps      = dds_sweep_pkg::B_steps,
  parameter int unsigned B_cnt        = dds_sweep_pkg::B_cnt
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [B_acumulador-1:0] inc_start,
  input  logic [B_acumulador-1:0] inc_step,
  input  logic [B_steps-1:0]      n_steps,
  input  logic [B_cnt-1:0]        settle_cycles,
  input  logic [B_cnt-1:0]        dwell_periods,
  input  logic                    zero_cross,
  input  logic                    step_ack,
  output logic [B_acumulador-1:0] incremento_fase,
  output logic                    dds_enable,
  output logic                    dds_reset_n,
  output logic                    acq_enable,
  output logic                    step_valid,
  output logic [B_steps-1:0]      step_index,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf
);

  sweep_state_t            r_state;
  sweep_state_t            w_state_next;
  logic [B_acumulador-1:0] r_inc;
  logic [B_acumulador-1:0] r_inc_step;
  logic [B_steps-1:0]      r_idx;
  logic [B_steps-1:0]      r_idx_last;
  logic [B_cnt-1:0]        r_settle_cfg;
  logic [B_cnt-1:0]        r_settle_cnt;
  logic [B_cnt-1:0]        r_dwell_eff;
  logic                    r_ovf;
  logic [B_acumulador:0]   w_sum;
  logic                    w_carry;
  logic                    w_last;
  logic                    w_start;
  logic                    w_dwell_tc;

  assign w_start = start && !abort;
  assign w_sum   = {1'b0, r_inc} + {1'b0, r_inc_step};
  assign w_carry = w_sum[B_acumulador];
  assign w_last  = (r_idx == r_idx_last);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_start) w_state_next = StSettle;
      end
      StSettle: begin
        if (abort)                    w_state_next = StIdle;
        else if (r_settle_cnt == '0)  w_state_next = StDwell;
      end
      StDwell: begin
        if (abort)           w_state_next = StIdle;
        else if (w_dwell_tc) w_state_next = StWaitAck;
      end
      StWaitAck: begin
        if (abort) begin
          w_state_next = StIdle;
        end else if (step_ack) begin
          // Overflowing increment truncates the sweep rather than wrapping.
          w_state_next = (w_last || w_carry) ? StDone : StSettle;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_inc        <= '0;
      r_inc_step   <= '0;
      r_idx        <= '0;
      r_idx_last   <= '0;
      r_settle_cfg <= '0;
      r_settle_cnt <= '0;
      r_dwell_eff  <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (w_start) begin
            // Configuration is frozen here for the whole sweep.
            r_inc        <= inc_start;
            r_inc_step   <= inc_step;
            r_idx        <= '0;
            r_idx_last   <= (n_steps == '0) ? '0 : n_steps - B_steps'(1);
            r_settle_cfg <= settle_cycles;
            r_settle_cnt <= settle_cycles;
            r_dwell_eff  <= (dwell_periods == '0) ? B_cnt'(1) : dwell_periods;
            r_ovf        <= 1'b0;
          end
        end
        StSettle: begin
          if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - B_cnt'(1);
        end
        StWaitAck: begin
          if (!abort && step_ack && !w_last) begin
            if (w_carry) begin
              r_ovf <= 1'b1;
            end else begin
              r_inc        <= w_sum[B_acumulador-1:0];
              r_idx        <= r_idx + B_steps'(1);
              r_settle_cnt <= r_settle_cfg;
            end
          end
        end
        default: ;
      endcase
    end
  end

  sweep_dwell_counter #(
    .Width (B_cnt)
  ) u_dwell_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (r_state != StDwell),
    .i_enable ((r_state == StDwell) && zero_cross),
    .i_target (r_dwell_eff),
    .o_tc     (w_dwell_tc)
  );

`ifdef SWEEP_PHASE_RESET_EN
  logic r_dds_reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dds_reset_n <= 1'b1;
    end else begin
      r_dds_reset_n <= !((w_state_next == StSettle) && (r_state != StSettle));
    end
  end

  assign dds_reset_n = r_dds_reset_n;
`else
  assign dds_reset_n = 1'b1;
`endif

  // Status outputs decode straight from the state so abort clears them on the same edge.
  assign busy            = (r_state != StIdle);
  assign dds_enable      = (r_state != StIdle);
  assign acq_enable      = (r_state == StDwell);
  assign step_valid      = (r_state == StWaitAck);
  assign done            = (r_state == StDone);
  assign incremento_fase = r_inc;
  assign step_index      = r_idx;
  assign ovf             = r_ovf;

endmodule

// File: tb/tb_dds_sweep_controller.sv
// tb_dds_sweep_controller
// Self-checking bench for dds_sweep_controller: directed sweeps plus randomized
// configurations, checked against a per-step timeline model of the sweep.
module tb_dds_sweep_controller;

  localparam int unsigned BA = 27;
  localparam int unsigned BS = 16;
  localparam int unsigned BC = 32;

`ifdef SWEEP_PHASE_RESET_EN
  localparam bit PhaseReset = 1'b1;
`else
  localparam bit PhaseReset = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [BA-1:0] inc_start;
  logic [BA-1:0] inc_step;
  logic [BS-1:0] n_steps;
  logic [BC-1:0] settle_cycles;
  logic [BC-1:0] dwell_periods;
  logic          zero_cross;
  logic          step_ack;
  logic [BA-1:0] incremento_fase;
  logic          dds_enable;
  logic          dds_reset_n;
  logic          acq_enable;
  logic          step_valid;
  logic [BS-1:0] step_index;
  logic          busy;
  logic          done;
  logic          ovf;

  int total = 0;
  int bad   = 0;
  int n_done;
  int n_rst_low;

  always #5 clk = ~clk;

  dds_sweep_controller dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .inc_start       (inc_start),
    .inc_step        (inc_step),
    .n_steps         (n_steps),
    .settle_cycles   (settle_cycles),
    .dwell_periods   (dwell_periods),
    .zero_cross      (zero_cross),
    .step_ack        (step_ack),
    .incremento_fase (incremento_fase),
    .dds_enable      (dds_enable),
    .dds_reset_n     (dds_reset_n),
    .acq_enable      (acq_enable),
    .step_valid      (step_valid),
    .step_index      (step_index),
    .busy            (busy),
    .done            (done),
    .ovf             (ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled mid-cycle on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (done) n_done++;
    if (!dds_reset_n) n_rst_low++;
  endtask

  // Runs one sweep from IDLE. abort_step >= 0 aborts in the DWELL of that step.
  task automatic run_sweep(input logic [BA-1:0] s_inc, input logic [BA-1:0] s_step,
                           input int n, input int settle, input int dwell,
                           input int abort_step);
    int            n_eff;
    int            d_eff;
    int            cnt;
    int            budget;
    int            entries;
    logic [BA:0]   sum;
    logic [BA-1:0] exp_inc;
    logic          last;
    logic          exp_ovf;
    n_eff = (n == 0) ? 1 : n;
    d_eff = (dwell == 0) ? 1 : dwell;
    inc_start     = s_inc;
    inc_step      = s_step;
    n_steps       = BS'(n);
    settle_cycles = BC'(settle);
    dwell_periods = BC'(dwell);
    zero_cross    = 1'b0;
    step_ack      = 1'b0;
    start         = 1'b1;
    n_done        = 0;
    n_rst_low     = 0;
    tick();
    start = 1'b0;
    // Config changes mid-sweep must have no effect.
    inc_start     = BA'($urandom);
    inc_step      = BA'($urandom);
    n_steps       = BS'($urandom_range(0, 7));
    settle_cycles = BC'($urandom_range(0, 7));
    dwell_periods = BC'($urandom_range(0, 7));
    check("start_busy", busy, 1);
    check("start_inc", incremento_fase, s_inc);
    check("start_idx", step_index, 0);
    check("start_ovf", ovf, 0);
    exp_inc = s_inc;
    entries = 1;
    for (int k = 0; k < n_eff; k++) begin
      for (int s = 0; s <= settle; s++) begin
        check("settle_acq", acq_enable, 0);
        check("settle_en", dds_enable, 1);
        check("settle_valid", step_valid, 0);
        zero_cross = 1'($urandom_range(0, 1));
        step_ack   = 1'($urandom_range(0, 1));
        tick();
      end
      cnt    = 0;
      budget = 0;
      while (cnt < d_eff && budget < 200) begin
        check("dwell_acq", acq_enable, 1);
        check("dwell_valid", step_valid, 0);
        if (k == abort_step) begin
          abort      = 1'b1;
          zero_cross = 1'b0;
          step_ack   = 1'b0;
          tick();
          abort = 1'b0;
          check("abort_busy", busy, 0);
          check("abort_acq", acq_enable, 0);
          check("abort_en", dds_enable, 0);
          check("abort_valid", step_valid, 0);
          repeat (4) tick();
          check("abort_no_done", n_done, 0);
          check("abort_ovf", ovf, 0);
          check("abort_idle", busy, 0);
          return;
        end
        zero_cross = 1'($urandom_range(0, 1));
        step_ack   = 1'($urandom_range(0, 1));
        if (zero_cross) cnt++;
        tick();
        budget++;
      end
      check("dwell_periods_seen", cnt, d_eff);
      zero_cross = 1'b0;
      step_ack   = 1'b0;
      check("wa_valid", step_valid, 1);
      check("wa_acq", acq_enable, 0);
      check("wa_en", dds_enable, 1);
      check("wa_idx", step_index, k);
      check("wa_inc", incremento_fase, exp_inc);
      repeat ($urandom_range(0, 3)) begin
        check("wa_hold", step_valid, 1);
        tick();
      end
      step_ack = 1'b1;
      tick();
      step_ack = 1'b0;
      check("ack_valid_drop", step_valid, 0);
      sum     = {1'b0, exp_inc} + {1'b0, s_step};
      last    = (k == n_eff - 1);
      exp_ovf = !last && sum[BA];
      if (last || sum[BA]) begin
        check("done_pulse", done, 1);
        check("end_ovf", ovf, exp_ovf);
        check("end_inc", incremento_fase, exp_inc);
        tick();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_en", dds_enable, 0);
        check("idle_inc_hold", incremento_fase, exp_inc);
        check("idle_ovf_hold", ovf, exp_ovf);
        check("done_count", n_done, 1);
        check("phase_reset_pulses", n_rst_low, PhaseReset ? entries : 0);
        return;
      end
      exp_inc = sum[BA-1:0];
      entries++;
      check("next_inc", incremento_fase, exp_inc);
      check("next_idx", step_index, k + 1);
      check("next_busy", busy, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ab;
    logic [BA-1:0] ri;
    logic [BA-1:0] rs;
    reset_n       = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    inc_start     = '0;
    inc_step      = '0;
    n_steps       = '0;
    settle_cycles = '0;
    dwell_periods = '0;
    zero_cross    = 1'b0;
    step_ack      = 1'b0;
    n_done        = 0;
    n_rst_low     = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_en", dds_enable, 0);
    check("rst_dds_reset_n", dds_reset_n, 1);
    check("rst_inc", incremento_fase, 0);
    check("rst_valid", step_valid, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_idx", step_index, 0);
    reset_n = 1'b1;
    tick();

    // Abort has priority over start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start", busy, 0);
    tick();

    run_sweep(BA'(1000), BA'(500), 3, 4, 2, -1);
    tick();
    run_sweep(BA'(134217000), BA'(1000), 3, 4, 2, -1);
    tick();
    run_sweep(BA'(1000), BA'(500), 3, 4, 2, 1);
    tick();
    run_sweep(BA'(777), BA'(3), 0, 0, 0, -1);
    tick();

    for (int i = 0; i < 16; i++) begin
      n = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) begin
        ri = BA'((1 << BA) - 1 - $urandom_range(0, 3000));
        rs = BA'($urandom_range(0, 2000));
      end else begin
        ri = BA'($urandom_range(0, 1 << 20));
        rs = BA'($urandom_range(0, 1 << 16));
      end
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, (n == 0) ? 0 : n - 1) : -1;
      run_sweep(ri, rs, n, $urandom_range(0, 5), $urandom_range(0, 4), ab);
      repeat ($urandom_range(1, 3)) tick();
      check("between_idle", busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
